i2s_tx: RTL and testbench
=========================

I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per BCLK half-period; legal range >= 2.
REQ-002 Port clk  input  1  single clock; all logic in this domain.
REQ-003 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 Port i_valid  input  1  upstream sample valid; sink side of the audio stream fed by the last dfb stage.
REQ-005 Port o_ready  output  1  sample accepted when i_valid && o_ready on a rising clk edge.
REQ-006 Port i_data  input  24  signed sample; accepted samples alternate left, right, left, ...
REQ-007 Port o_bclk  output  1  I2S bit clock.
REQ-008 Port o_lrclk  output  1  I2S word select; 0 = left slot, 1 = right slot.
REQ-009 Port o_sdata  output  1  I2S serial data, MSB first.
REQ-010 Port o_underrun  output  1  one-clk pulse when a frame starts without a complete L/R pair.

Function
REQ-011 Divider counter 0..CLK_DIV-1 shall wrap each CLK_DIV clks; o_bclk shall toggle on every wrap.
REQ-012 Fall tick = wrap while o_bclk==1; o_lrclk, o_sdata and the bit counter shall update only on fall ticks.
REQ-013 6-bit bit counter (0..63) shall increment on each fall tick, wrapping 63->0; frame = 64 BCLK, two 32-bit slots.
REQ-014 o_lrclk shall equal bit_cnt[5] after each update.
REQ-015 Slot position p = bit_cnt[4:0]: o_sdata = sample bit (24-p) for p in 1..24, else 0; one-BCLK I2S delay after the LRCLK edge.
REQ-016 Input buffer: two 24-bit entries (L, R) plus count 0..2; o_ready = (count < 2), combinational from count only.
REQ-017 Accepted samples shall be written to L when count==0 and to R when count==1.
REQ-018 Frame start = fall tick where bit_cnt goes 63->0.
REQ-019 At frame start with count==2: both entries load into the L/R shift registers and count clears to 0 in the same edge.
REQ-020 At frame start with count<2: the frame transmits all zeros, o_underrun pulses for that one clk, and the buffer is left intact. A lone L entry waits for its R partner, which preserves channel pairing.
REQ-021 A write and a frame load cannot coincide, because count==2 forces o_ready low; no other simultaneous-event rule is needed.
REQ-022 Loaded samples shall remain stable in the shift registers for the whole frame, independent of new writes.
REQ-023 First BCLK rise at clk edge CLK_DIV after reset release; first fall tick, which is also the first frame start, at edge 2*CLK_DIV.

Reset
REQ-024 While rst_n low: o_bclk=0, o_lrclk=1, o_sdata=0, o_underrun=0, o_ready=1.
REQ-025 While rst_n low: divider=0, bit_cnt=63, count=0, shift registers=0.
REQ-026 Reset asserted mid-frame shall abort the frame immediately, discard buffered samples, and restart pairing at left.

Structure
REQ-027 audio_pkg shall hold SAMPLE_WIDTH=24, SLOT_WIDTH=32, FRAME_BITS=64 and typedef sample_t (logic signed [23:0]).
REQ-028 Sub-module i2s_clkgen shall contain the divider, o_bclk, fall tick and bit counter.
REQ-029 The i2s_tx top shall contain the buffer, frame load and serializer.

Verification
REQ-030 All scenarios run with CLK_DIV=2: BCLK period 4 clk, frame 256 clk.
REQ-031 Reset scenario: hold rst_n low for 5 clk -> o_bclk=0, o_lrclk=1, o_sdata=0, o_ready=1, o_underrun=0.
REQ-032 Single-frame scenario: drive 0xA5A5A5 then 0x123456 before edge 4 -> on bits 1..24 sdata is A5A5A5 MSB first with lrclk=0; on bits 33..56 sdata is 123456 with lrclk=1; zeros elsewhere; no underrun.
REQ-033 Starvation scenario: hold i_valid=0 -> o_underrun pulses at clk edges 4, 260, 516; o_sdata constantly 0; o_lrclk toggles every 128 clk.
REQ-034 Backpressure scenario: hold i_valid=1 with 4 distinct samples queued -> 2 accepted, o_ready low until frame start, 3rd accepted on the first clk after the load; output frames carry pairs (s0,s1) then (s2,s3).
REQ-035 Partial-pair scenario: send only 0x000001 before the first frame start -> zero frame plus underrun; then send 0x000002 -> next frame plays L=000001, R=000002.
REQ-036 Mid-frame reset scenario: pulse rst_n low at bit 40 -> all outputs take reset values within the same edge; a new pair then plays from the first frame after reset.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared audio constants, the sample type and the slot-bit helper
// used by the I2S transmitter.
//   SAMPLE_WIDTH : bits per audio sample (24)
//   SLOT_WIDTH   : BCLK periods per channel slot (32)
//   FRAME_BITS   : BCLK periods per L/R frame (64)
//   sample_t     : signed 24-bit audio sample
package audio_pkg;

    localparam int SAMPLE_WIDTH = 24;
    localparam int SLOT_WIDTH   = 32;
    localparam int FRAME_BITS   = 64;
    localparam int BIT_CNT_W    = 6;

    typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

    // Serial bit carried at slot position pos. Position 0 is the I2S
    // one-BCLK delay slot. Positions 1..24 carry the sample MSB first.
    // Positions 25..31 are zero padding.
    function automatic logic slot_bit(sample_t s, logic [4:0] pos);
        logic [4:0] idx;
        idx = 5'(SAMPLE_WIDTH) - pos;
        if (pos >= 5'd1 && pos <= 5'(SAMPLE_WIDTH)) begin
            return s[idx];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/i2s_tx_if.sv
// i2s_tx_if: audio sample stream into the I2S transmitter.
//   i_valid : source has a sample on i_data
//   o_ready : sink can take a sample this cycle
//   i_data  : signed 24-bit sample; successive samples alternate L, R, L, ...
// Handshake: a sample transfers on every rising clk edge where
// i_valid && o_ready. Once the source raises i_valid, it holds i_valid and
// i_data stable until that transfer happens. o_ready does not depend on
// i_valid.
interface i2s_tx_if;
    import audio_pkg::*;

    logic    i_valid;
    logic    o_ready;
    sample_t i_data;

    modport master (output i_valid, output i_data, input o_ready);
    modport slave  (input i_valid, input i_data, output o_ready);

endinterface

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: BCLK divider and frame bit counter.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   o_bclk      : bit clock, toggles every CLK_DIV clk cycles
//   o_fall_tick : one-clk strobe on the clk edge where BCLK falls
//   o_bit_cnt   : bit position within the 64-BCLK frame (reset value 63)
// CLK_DIV must be at least 2.
module i2s_clkgen
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 o_bclk,
    output logic                 o_fall_tick,
    output logic [BIT_CNT_W-1:0] o_bit_cnt
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0]     div_q, div_d;
    logic                 bclk_q, bclk_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 wrap;
    logic                 fall_tick;

    always_comb begin
        wrap      = (div_q == DIV_MAX);
        div_d     = wrap ? '0 : div_q + DIV_W'(1);
        bclk_d    = wrap ? ~bclk_q : bclk_q;
        fall_tick = wrap && bclk_q;
        // Frame position wraps 63 -> 0 naturally in 6 bits.
        bit_cnt_d = fall_tick ? bit_cnt_q + BIT_CNT_W'(1) : bit_cnt_q;
    end

    // Bit counter resets to 63, so the first fall tick is a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '1;
        end else begin
            div_q     <= div_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign o_bclk      = bclk_q;
    assign o_fall_tick = fall_tick;
    assign o_bit_cnt   = bit_cnt_q;

endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S transmitter with a two-entry L/R sample buffer.
//   clk, rst_n : system clock, asynchronous active-low reset
//   s_if       : sample stream (slave side), samples alternate L, R
//   o_bclk     : I2S bit clock (CLK_DIV clk per half-period)
//   o_lrclk    : word select, 0 = left slot, 1 = right slot
//   o_sdata    : serial data, MSB first, one BCLK after each LRCLK edge
//   o_underrun : one-clk pulse when a frame starts without a full L/R pair
module i2s_tx
    import audio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    i2s_tx_if.slave  s_if,
    output logic     o_bclk,
    output logic     o_lrclk,
    output logic     o_sdata,
    output logic     o_underrun
);

    logic                 fall_tick;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_nxt;

    i2s_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk         (clk),
        .rst_n       (rst_n),
        .o_bclk      (o_bclk),
        .o_fall_tick (fall_tick),
        .o_bit_cnt   (bit_cnt)
    );

    logic [1:0] count_q, count_d;
    sample_t    buf_l_q, buf_l_d;
    sample_t    buf_r_q, buf_r_d;
    sample_t    frm_l_q, frm_l_d;
    sample_t    frm_r_q, frm_r_d;
    logic       sdata_q, sdata_d;
    logic       underrun_q, underrun_d;

    logic       ready;
    logic       accept;
    logic       frame_start;

    always_comb begin
        ready       = (count_q < 2'd2);
        accept      = s_if.i_valid && ready;
        frame_start = fall_tick && (bit_cnt == '1);
        bit_nxt     = bit_cnt + BIT_CNT_W'(1);

        count_d    = count_q;
        buf_l_d    = buf_l_q;
        buf_r_d    = buf_r_q;
        frm_l_d    = frm_l_q;
        frm_r_d    = frm_r_q;
        sdata_d    = sdata_q;
        underrun_d = 1'b0;

        if (accept) begin
            if (count_q == 2'd0) begin
                buf_l_d = s_if.i_data;
            end else begin
                buf_r_d = s_if.i_data;
            end
            count_d = count_q + 2'd1;
        end

        // A load needs count==2, which holds ready low. So a load never
        // coincides with a write. An incomplete pair stays in the buffer
        // so that channel pairing survives a starved frame.
        if (frame_start) begin
            if (count_q == 2'd2) begin
                frm_l_d = buf_l_q;
                frm_r_d = buf_r_q;
                count_d = 2'd0;
            end else begin
                frm_l_d    = '0;
                frm_r_d    = '0;
                underrun_d = 1'b1;
            end
        end

        // On a frame start bit_nxt is 0, a delay slot that is always zero.
        // So the frame registers can be read before the load lands.
        if (fall_tick) begin
            sdata_d = slot_bit(bit_nxt[5] ? frm_r_q : frm_l_q, bit_nxt[4:0]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            buf_l_q    <= '0;
            buf_r_q    <= '0;
            frm_l_q    <= '0;
            frm_r_q    <= '0;
            sdata_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            buf_l_q    <= buf_l_d;
            buf_r_q    <= buf_r_d;
            frm_l_q    <= frm_l_d;
            frm_r_q    <= frm_r_d;
            sdata_q    <= sdata_d;
            underrun_q <= underrun_d;
        end
    end

    assign s_if.o_ready = ready;
    assign o_lrclk      = bit_cnt[5];
    assign o_sdata      = sdata_q;
    assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx with CLK_DIV=2.
// Edge numbering: edge N is the N-th rising clk edge after rst_n is released.
// Outputs are sampled 1 time unit after an edge.
module tb_i2s_tx;
    import audio_pkg::*;

    localparam int CLK_DIV = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2s_tx_if s_if ();
    logic bclk, lrclk, sdata, underrun;

    i2s_tx #(.CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_if       (s_if.slave),
        .o_bclk     (bclk),
        .o_lrclk    (lrclk),
        .o_sdata    (sdata),
        .o_underrun (underrun)
    );

    int edge_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    int checks   = 0;
    int failures = 0;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic at_edge(input int e);
        int guard;
        guard = 0;
        while (edge_cnt < e) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 2000) begin
                $display("FAIL at_edge_timeout: reached edge %0d expected %0d", edge_cnt, e);
                $fatal(1, "edge wait expired");
            end
        end
    endtask

    task automatic do_reset(input bit with_checks);
        rst_n = 1'b0;
        s_if.i_valid = 1'b0;
        s_if.i_data  = '0;
        repeat (5) @(posedge clk);
        #1;
        if (with_checks) begin
            check("rst_bclk", bclk, 0);
            check("rst_lrclk", lrclk, 1);
            check("rst_sdata", sdata, 0);
            check("rst_ready", s_if.o_ready, 1);
            check("rst_underrun", underrun, 0);
        end
        rst_n = 1'b1;
    endtask

    // Drive one sample at edge point e; it is taken on edge e+1.
    task automatic send(input sample_t d, input int e);
        at_edge(e);
        s_if.i_valid = 1'b1;
        s_if.i_data  = d;
        at_edge(e + 1);
        s_if.i_valid = 1'b0;
    endtask

    // Expected I2S line value for frame bit b.
    function automatic logic exp_bit(input int b, input sample_t l, input sample_t r);
        int p;
        sample_t s;
        p = b % 32;
        s = (b < 32) ? l : r;
        if (p >= 1 && p <= 24) return s[24 - p];
        return 1'b0;
    endfunction

    // Checks every bit of frame f. Bit b is sampled mid-BCLK, after edge 4+256f+4b+2.
    task automatic check_frame(input int f, input sample_t l, input sample_t r, input string name);
        int bad_sd, bad_lr, first_b;
        logic got_sd, got_lr, e_sd, e_lr;
        bad_sd = 0; bad_lr = 0; first_b = -1;
        got_sd = 0; got_lr = 0; e_sd = 0; e_lr = 0;
        for (int b = 0; b < FRAME_BITS; b++) begin
            at_edge(4 + 256 * f + 4 * b + 2);
            if (sdata !== exp_bit(b, l, r)) begin
                if (bad_sd == 0) begin
                    first_b = b; got_sd = sdata; e_sd = exp_bit(b, l, r);
                end
                bad_sd++;
            end
            if (lrclk !== (b >= 32)) begin
                if (bad_lr == 0) begin
                    got_lr = lrclk; e_lr = (b >= 32);
                end
                bad_lr++;
            end
        end
        checks++;
        if (bad_sd != 0) begin
            failures++;
            $display("FAIL %s_sdata: %0d bad bits, first bit %0d got %0b expected %0b",
                     name, bad_sd, first_b, got_sd, e_sd);
        end
        checks++;
        if (bad_lr != 0) begin
            failures++;
            $display("FAIL %s_lrclk: %0d bad bits, got %0b expected %0b", name, bad_lr, got_lr, e_lr);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string name;
        int    bit_idx;
        logic  exp_sdata;
        logic  exp_lrclk;
    } vec_t;

    vec_t vecs[14];

    initial begin
        sample_t     bp_q[$];
        sample_t     bp_s[4];
        int          acc_edges[$];
        logic        rdy_hist[$];
        int          k;
        int          exp_acc[4];

        // Frame of L=A5A5A5, R=123456, bits computed by hand
        vecs[0]  = '{"b0_delay",   0, 1'b0, 1'b0};
        vecs[1]  = '{"b1_msb",     1, 1'b1, 1'b0};
        vecs[2]  = '{"b2",         2, 1'b0, 1'b0};
        vecs[3]  = '{"b3",         3, 1'b1, 1'b0};
        vecs[4]  = '{"b6",         6, 1'b1, 1'b0};
        vecs[5]  = '{"b24_lsb",   24, 1'b1, 1'b0};
        vecs[6]  = '{"b25_pad",   25, 1'b0, 1'b0};
        vecs[7]  = '{"b31_pad",   31, 1'b0, 1'b0};
        vecs[8]  = '{"b32_delay", 32, 1'b0, 1'b1};
        vecs[9]  = '{"b33_msb",   33, 1'b0, 1'b1};
        vecs[10] = '{"b36",       36, 1'b1, 1'b1};
        vecs[11] = '{"b39",       39, 1'b1, 1'b1};
        vecs[12] = '{"b55",       55, 1'b1, 1'b1};
        vecs[13] = '{"b56_lsb",   56, 1'b0, 1'b1};

        s_if.i_valid = 1'b0;
        s_if.i_data  = '0;

        // ---- reset + single frame ----
        do_reset(1'b1);
        send(24'hA5A5A5, 0);
        check("sf_ready_after_l", s_if.o_ready, 1);
        send(24'h123456, 1);
        check("sf_ready_full", s_if.o_ready, 0);
        check("sf_bclk_e2", bclk, 1);
        check("sf_lrclk_e2", lrclk, 1);
        at_edge(3);
        check("sf_bclk_e3", bclk, 1);
        check("sf_underrun_e3", underrun, 0);
        at_edge(4);
        check("sf_bclk_e4", bclk, 0);
        check("sf_lrclk_e4", lrclk, 0);
        check("sf_underrun_e4", underrun, 0);
        check("sf_ready_after_load", s_if.o_ready, 1);
        for (int i = 0; i < 14; i++) begin
            at_edge(4 + 4 * vecs[i].bit_idx + 2);
            check({"sf_sdata_", vecs[i].name}, sdata, vecs[i].exp_sdata);
            check({"sf_lrclk_", vecs[i].name}, lrclk, vecs[i].exp_lrclk);
        end

        // ---- starvation ----
        do_reset(1'b0);
        at_edge(3);
        check("st_underrun_e3", underrun, 0);
        at_edge(4);
        check("st_underrun_e4", underrun, 1);
        at_edge(5);
        check("st_underrun_e5", underrun, 0);
        check_frame(0, 24'h0, 24'h0, "st_f0");
        at_edge(259);
        check("st_underrun_e259", underrun, 0);
        check("st_lrclk_e259", lrclk, 1);
        at_edge(260);
        check("st_underrun_e260", underrun, 1);
        check("st_lrclk_e260", lrclk, 0);
        check_frame(1, 24'h0, 24'h0, "st_f1");
        at_edge(516);
        check("st_underrun_e516", underrun, 1);

        // ---- backpressure ----
        do_reset(1'b0);
        bp_s = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        for (int i = 0; i < 4; i++) bp_q.push_back(bp_s[i]);
        k = 0;
        while (bp_q.size() > 0 && k < 20) begin
            at_edge(k);
            s_if.i_valid = 1'b1;
            s_if.i_data  = bp_q[0];
            rdy_hist.push_back(s_if.o_ready);
            if (s_if.o_ready) begin
                acc_edges.push_back(k + 1);
                void'(bp_q.pop_front());
            end
            k++;
        end
        at_edge(k);
        s_if.i_valid = 1'b0;
        exp_acc = '{1, 2, 5, 6};
        check("bp_accept_count", acc_edges.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < acc_edges.size()) check($sformatf("bp_accept_edge%0d", i), acc_edges[i], exp_acc[i]);
            else check($sformatf("bp_accept_edge%0d", i), 0, exp_acc[i]);
        end
        if (rdy_hist.size() > 4) begin
            check("bp_ready_e2", rdy_hist[2], 0);
            check("bp_ready_e3", rdy_hist[3], 0);
            check("bp_ready_e4", rdy_hist[4], 1);
        end else begin
            check("bp_ready_hist_len", rdy_hist.size(), 5);
        end
        check_frame(0, bp_s[0], bp_s[1], "bp_f0");
        check_frame(1, bp_s[2], bp_s[3], "bp_f1");

        // ---- partial pair ----
        do_reset(1'b0);
        send(24'h000001, 0);
        check("pp_ready_one", s_if.o_ready, 1);
        at_edge(4);
        check("pp_underrun_e4", underrun, 1);
        check("pp_ready_kept", s_if.o_ready, 1);
        check_frame(0, 24'h0, 24'h0, "pp_f0");
        send(24'h000002, 258);
        check("pp_ready_full", s_if.o_ready, 0);
        at_edge(260);
        check("pp_underrun_e260", underrun, 0);
        check_frame(1, 24'h000001, 24'h000002, "pp_f1");

        // ---- mid-frame reset ----
        do_reset(1'b0);
        send(24'h0F0F0F, 0);
        send(24'hF0F0F0, 1);
        send(24'h777777, 100);
        at_edge(4 + 4 * 40);
        check("mr_lrclk_before", lrclk, 1);
        rst_n = 1'b0;
        #1;
        check("mr_bclk", bclk, 0);
        check("mr_lrclk", lrclk, 1);
        check("mr_sdata", sdata, 0);
        check("mr_ready", s_if.o_ready, 1);
        check("mr_underrun", underrun, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(24'h0ABCDE, 0);
        send(24'h654321, 1);
        at_edge(4);
        check("mr_underrun_e4", underrun, 0);
        check_frame(0, 24'h0ABCDE, 24'h654321, "mr_f0");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
